conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 2-D convolution engine for the edge-detection pipeline; the next generation of the
//  single-window conv block. Accepts a raster pixel stream, keeps two line buffers, and applies a
//  run-time programmable signed 3x3 kernel to every complete window ("valid" convolution, no padding).
//  The output is clamped or absolute-valued, then saturated; it feeds the thresholding stage.
// PARAMETERS
//  DATA_W  8  unsigned input pixel width
//  COEF_W  5  signed kernel coefficient width (two's complement)
//  OUT_W   8  unsigned output pixel width
//  IMG_W   8  pixels per line (>=3)
//  IMG_H   8  lines per frame (>=3)
// PORTS
//  clk        in   1                      rising-edge clock
//  rst_n      in   1                      asynchronous active-low reset
//  pix_valid  in   1                      pix_in is accepted on this edge (no backpressure)
//  sof        in   1                      with pix_valid: this pixel is (row 0, col 0) of a new frame
//  pix_in     in   DATA_W                 pixel, raster order
//  mode       in   1                      0: clamp negatives to 0; 1: take absolute value
//  coef_we    in   1                      kernel write strobe
//  coef_addr  in   4                      coefficient index 0..8, row-major (4 = centre); 9..15 ignored
//  coef_data  in   COEF_W                 signed coefficient
//  out_valid  out  1                      one-cycle strobe per output pixel
//  out_pix    out  OUT_W                  convolved, saturated pixel
//  frame_done out  1                      one-cycle strobe coincident with the last out_valid of a frame
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_pix=0, frame_done=0, row/col counters=0, pipeline valids=0.
//   Kernel reloads the default Laplacian: centre=+8, all others=-1. Line-buffer RAM is not cleared.
//  Position: the col counter increments per accepted pixel and wraps IMG_W-1 -> 0, incrementing row.
//   Row wraps IMG_H-1 -> 0 (an implicit new frame). sof with pix_valid forces the pixel to (0,0),
//   regardless of the counters. sof without pix_valid is ignored.
//  Window: the pixel accepted at (r,c) completes window rows r-2..r, cols c-2..c. A window is valid
//   only if r>=2 && c>=2. Each frame gives (IMG_W-2)*(IMG_H-2) outputs.
//  Pipeline: stage 1 registers 9 products pix*coef, each signed DATA_W+COEF_W+1 bits.
//   Stage 2 registers their sum; the accumulator is signed DATA_W+COEF_W+5 bits and cannot overflow.
//   Stage 3 registers the output. Latency: completing pixel accepted at edge N -> out_valid=1 during
//   the cycle after edge N+3, for exactly one cycle. Back-to-back pixels give back-to-back outputs.
//  Output rule: s = sum.
//   mode0: out = s<0 ? 0 : min(s, 2^OUT_W-1).
//   mode1: out = min(|s|, 2^OUT_W-1).
//   mode is sampled at stage 3.
//  out_pix holds its last value while out_valid=0.
//  Coefficients: a write at edge N updates register coef_addr. A window whose completing pixel is
//   accepted at edge N+1 or later uses the new value; earlier windows use the old value.
//   Writes to addr>=9 have no effect. A write is allowed concurrently with streaming.
//  Gaps: pix_valid may drop for any number of cycles. Window/counter state is held; the pipeline
//   keeps draining in-flight results.
//  sof mid-frame: counters restart. Results already in the pipeline still emerge. frame_done is not
//   issued for the truncated frame. Rows 0-1 of the new frame produce no output.
//  frame_done=1 with the out_valid of the window completed at (IMG_H-1, IMG_W-1).
//  Reset mid-operation: all in-flight results are discarded immediately; no out_valid after rst_n
//   deasserts until a new valid window completes.
// TESTING
//  T1 IMG_W=IMG_H=3, default kernel, sof+pixels 1..9 -> single out_valid, out_pix=0 (8*5-40),
//     frame_done=1 in the same cycle, 4 cycles after pixel 9.
//  T2 write all 9 coefs=+1, repeat 1..9 -> out_pix=45 (mode0 and mode1).
//  T3 coefs: centre=-1, others=0; frame of all 5s -> mode0 out_pix=0; mode1 out_pix=5.
//     Centre=+15, all pixels 255 -> out_pix=255 (saturated).
//  T4 IMG_W=IMG_H=4, pixels 0..15, coefs all +1 -> exactly 4 out_valid.
//     Values 45, 54, 81, 90 in order; frame_done only with 90. Random pix_valid gaps give identical values.
//  T5 sof asserted at pixel 6 of a 4x4 frame -> no frame_done for that frame.
//     Next full frame is correct.
//  T6 rst_n pulsed low 1 cycle after a completing pixel -> out_valid stays 0.
//     Kernel reads back as Laplacian: a frame of 1..9 gives out_pix=0.

Source files
------------

// File: rtl/conv3x3_if.sv
// Pixel-stream, kernel-write and result bundle for the streaming 3x3 convolution engine.
// The master drives pixels and coefficients; the slave (engine) returns results.
interface conv3x3_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 5,
    parameter int OUT_W  = 8
);
    logic              pix_valid;
    logic              sof;
    logic [DATA_W-1:0] pix_in;
    logic              mode;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [OUT_W-1:0]  out_pix;
    logic              frame_done;

    modport master (
        output pix_valid, sof, pix_in, mode, coef_we, coef_addr, coef_data,
        input  out_valid, out_pix, frame_done
    );
    modport slave (
        input  pix_valid, sof, pix_in, mode, coef_we, coef_addr, coef_data,
        output out_valid, out_pix, frame_done
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers feed a 3x3 window, then products -> sum -> clamp/abs + saturate.
// Completing pixel at edge N yields out_valid after edge N+3.
module conv3x3_stream #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 5,
    parameter int OUT_W  = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    conv3x3_if.slave   bus
);
    localparam int PW = DATA_W + COEF_W + 1;
    localparam int SW = DATA_W + COEF_W + 5;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << OUT_W) - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          acc, win_vld, win_last;

    logic [DATA_W-1:0] lb_far  [IMG_W];
    logic [DATA_W-1:0] lb_near [IMG_W];

    logic [2:0][2:0][DATA_W-1:0] win_q;
    logic signed [COEF_W-1:0]    coef_q [9];
    logic                        wr_pend_q;
    logic [3:0]                  wr_addr_q;
    logic [COEF_W-1:0]           wr_data_q;

    logic signed [PW-1:0] prod_q [9];
    logic signed [SW-1:0] sum_q, sum_d, mag;
    logic [OUT_W-1:0]     out_pix_q, sat_pix;
    logic [3:0]           vld_pipe_q, last_pipe_q;

    always_comb begin
        acc     = bus.pix_valid;
        cur_col = bus.sof ? '0 : col_q;
        cur_row = bus.sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (acc) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
        win_vld  = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        win_last = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    end

    // lb_near holds row r-1, lb_far row r-2 at each column; contents need no reset
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_far[cur_col]  <= lb_near[cur_col];
            lb_near[cur_col] <= bus.pix_in;
        end
    end

    // Writes land one cycle late so the window completing on the write edge still sees the old kernel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int k = 0; k < 9; k++)
                coef_q[k] <= (k == 4) ? COEF_W'(8) : {COEF_W{1'b1}};
        end else begin
            wr_pend_q <= bus.coef_we && (bus.coef_addr < 4'd9);
            wr_addr_q <= bus.coef_addr;
            wr_data_q <= bus.coef_data;
            if (wr_pend_q) coef_q[wr_addr_q] <= wr_data_q;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) sum_d = sum_d + SW'(prod_q[k]);
    end

    always_comb begin
        if (sum_q < 0) mag = bus.mode ? -sum_q : {SW{1'b0}};
        else           mag = sum_q;
        sat_pix = (mag > MAXV) ? {OUT_W{1'b1}} : mag[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            sum_q       <= '0;
            out_pix_q   <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            for (int k = 0; k < 9; k++) prod_q[k] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            vld_pipe_q  <= {vld_pipe_q[2:0], win_vld};
            last_pipe_q <= {last_pipe_q[2:0], win_vld && win_last};
            if (acc) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb_far[cur_col];
                win_q[1][2] <= lb_near[cur_col];
                win_q[2][2] <= bus.pix_in;
            end
            if (vld_pipe_q[0])
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        prod_q[i*3+j] <= PW'($signed({1'b0, win_q[i][j]})) * PW'(coef_q[i*3+j]);
            if (vld_pipe_q[1]) sum_q <= sum_d;
            if (vld_pipe_q[2]) out_pix_q <= sat_pix;
        end
    end

    assign bus.out_valid  = vld_pipe_q[3];
    assign bus.frame_done = last_pipe_q[3];
    assign bus.out_pix    = out_pix_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on a 4x4 frame: directed kernels plus randomized streaming,
// with a frame-array reference model feeding a scoreboard queue drained by an output monitor.
module tb_conv3x3_stream;
    localparam int DW = 8, CWT = 5, OW = 8, W = 4, H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv3x3_if #(.DATA_W(DW), .COEF_W(CWT), .OUT_W(OW)) bus ();

    conv3x3_stream #(.DATA_W(DW), .COEF_W(CWT), .OUT_W(OW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int pix; bit done; } exp_t;
    exp_t q[$];
    int   outlog[$];
    int   checks = 0, errors = 0;
    int   kern[9];
    int   img[H][W];
    int   prow, pcol, last_exp;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(input int s, input bit m);
        int v;
        v = s;
        if (v < 0) v = m ? -v : 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 8 : -1;
        prow = 0;
        pcol = 0;
        last_exp = 0;
        q.delete();
    endfunction

    // One clock of stimulus; the model sees the pixel before any same-cycle kernel write
    task automatic cyc(input bit pv, input bit s, input int pix,
                       input bit we = 0, input int addr = 0, input int data = 0);
        int r, c, sum;
        @(negedge clk);
        bus.pix_valid = pv;
        bus.sof       = s;
        bus.pix_in    = DW'(pix);
        bus.coef_we   = we;
        bus.coef_addr = 4'(addr);
        bus.coef_data = CWT'(data);
        if (pv) begin
            r = s ? 0 : prow;
            c = s ? 0 : pcol;
            img[r][c] = pix;
            if (r >= 2 && c >= 2) begin
                sum = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        sum += kern[i*3+j] * img[r-2+i][c-2+j];
                q.push_back('{sat(sum, bus.mode), (r == H-1) && (c == W-1)});
            end
            pcol = (c + 1) % W;
            prow = (c == W-1) ? (r + 1) % H : r;
        end
        if (we && addr < 9) kern[addr] = data;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(0, 0, 0);
        check("drain_empty", q.size(), 0);
        repeat (3) cyc(0, 0, 0);
    endtask

    task automatic set_mode(input bit m);
        cyc(0, 0, 0);
        bus.mode = m;
    endtask

    task automatic set_kernel(input int others, input int centre);
        for (int a = 0; a < 9; a++) cyc(0, 0, 0, 1, a, (a == 4) ? centre : others);
    endtask

    task automatic frame(input int base, input int step, input bit gaps, input bit first_sof);
        for (int p = 0; p < W*H; p++) begin
            if (gaps) repeat ($urandom_range(0, 3)) cyc(0, 0, 0);
            cyc(1, first_sof && (p == 0), (base + step*p) & 255);
        end
    endtask

    task automatic check_log(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check({name, "_count"}, outlog.size(), 4);
        for (int i = 0; i < 4 && i < outlog.size(); i++) check(name, outlog[i], e[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.pix_valid = 0; bus.sof = 0; bus.coef_we = 0;
        model_reset();
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pix", bus.out_pix, 0);
        check("rst_frame_done", bus.frame_done, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every output strobe must match the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pix %0d done %0d expected no output at %0t",
                             bus.out_pix, bus.frame_done, $time);
                end else begin
                    e = q.pop_front();
                    check("out_pix", bus.out_pix, e.pix);
                    check("frame_done", bus.frame_done, e.done);
                    last_exp = e.pix;
                    outlog.push_back(int'(bus.out_pix));
                end
            end else begin
                check("done_without_valid", bus.frame_done, 0);
                check("out_pix_hold", bus.out_pix, last_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = 0; bus.sof = 0; bus.pix_in = '0; bus.mode = 0;
        bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_out_valid", bus.out_valid, 0);
        check("init_out_pix", bus.out_pix, 0);
        check("init_frame_done", bus.frame_done, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Default Laplacian on a ramp, plus frame_done latency of the last window
        frame(0, 1, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0);
            check("latency_done", bus.frame_done, k == 4);
        end
        drain();

        // All-ones kernel: box sums 45,54,81,90 in both modes and with gaps
        set_kernel(1, 1);
        outlog.delete(); frame(0, 1, 0, 1); drain(); check_log("box_mode0", 45, 54, 81, 90);
        set_mode(1);
        outlog.delete(); frame(0, 1, 0, 1); drain(); check_log("box_mode1", 45, 54, 81, 90);
        set_mode(0);
        outlog.delete(); frame(0, 1, 1, 1); drain(); check_log("box_gaps", 45, 54, 81, 90);

        // Negative centre: clamp vs abs; then saturation
        set_kernel(0, -1);
        outlog.delete(); frame(5, 0, 0, 1); drain(); check_log("neg_mode0", 0, 0, 0, 0);
        set_mode(1);
        outlog.delete(); frame(5, 0, 0, 1); drain(); check_log("neg_mode1", 5, 5, 5, 5);
        set_mode(0);
        set_kernel(0, 15);
        outlog.delete(); frame(255, 0, 0, 1); drain(); check_log("saturate", 255, 255, 255, 255);

        // sof mid-frame, then a full frame and an implicit-wrap frame
        set_kernel(1, 1);
        for (int p = 0; p < 6; p++) cyc(1, p == 0, 100 + p);
        outlog.delete(); frame(0, 1, 0, 1); frame(0, 1, 0, 0); drain();
        check("sof_restart_count", outlog.size(), 8);

        // Randomized streaming with concurrent kernel writes and stray sof
        for (int blk = 0; blk < 4; blk++) begin
            set_mode(blk[0]);
            for (int n = 0; n < 150; n++)
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 255),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 15), int'($urandom_range(0, 31)) - 16);
            drain();
        end

        // Reset one cycle after a completing pixel: result dropped, kernel back to Laplacian
        set_mode(0);
        set_kernel(1, 1);
        for (int p = 0; p < 11; p++) cyc(1, p == 0, p + 1);
        cyc(0, 0, 0);
        do_reset();
        outlog.delete();
        repeat (8) cyc(0, 0, 0);
        check("reset_no_output", outlog.size(), 0);
        frame(1, 1, 0, 1); drain(); check_log("reset_laplacian", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
